// File: rtl/graph_pkg.sv
// Shared graph-generator types: normalized event, raw sensor event, cube and window geometry.
package graph_pkg;

    localparam int GRAPH_SIZE      = 128;
    localparam int GRAPH_BIT_WIDTH = $clog2(GRAPH_SIZE);
    localparam int TIME_WINDOW     = 200000;
    localparam int SENSOR_W        = 34;
    localparam int SENSOR_H        = 34;
    localparam int TS_WIDTH        = 32;

    typedef struct packed {
        logic                       valid;
        logic [GRAPH_BIT_WIDTH-1:0] x;
        logic [GRAPH_BIT_WIDTH-1:0] y;
        logic [GRAPH_BIT_WIDTH-1:0] t;
        logic                       p;
    } event_type;

    typedef struct packed {
        logic [15:0]         x;
        logic [15:0]         y;
        logic [TS_WIDTH-1:0] ts;
        logic                p;
    } raw_event_type;

    typedef enum logic {
        IDLE,
        ACTIVE
    } win_state_t;

endpackage

// File: rtl/event_normalizer_if.sv
// Raw-event input handshake, flush, and normalized-event output bundle of the event normalizer.
interface event_normalizer_if #(
    parameter int TS_WIDTH = 32
);
    import graph_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_x;
    logic [15:0]         in_y;
    logic [TS_WIDTH-1:0] in_ts;
    logic                in_p;
    logic                flush;
    event_type           ev_out;
    logic                ev_out_ready;
    logic                new_window;
    logic [15:0]         drop_cnt;

    modport master (
        output in_valid, in_x, in_y, in_ts, in_p, flush, ev_out_ready,
        input  in_ready, ev_out, new_window, drop_cnt
    );

    modport slave (
        input  in_valid, in_x, in_y, in_ts, in_p, flush, ev_out_ready,
        output in_ready, ev_out, new_window, drop_cnt
    );

endinterface

// File: rtl/norm_scale.sv
// One-axis fixed-point scaler: (din * COEF) >> SHIFT, clamped to MAX_VAL, registered when en is high.
module norm_scale #(
    parameter int              DATA_W  = 16,
    parameter longint unsigned COEF    = 1,
    parameter int              SHIFT   = 16,
    parameter int              OUT_W   = 7,
    parameter int              MAX_VAL = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [OUT_W-1:0]  dout
);

    localparam int COEF_W = $clog2(COEF + 1);
    localparam int PROD_W = DATA_W + COEF_W;

    logic [PROD_W-1:0] prod_p1;
    logic [PROD_W-1:0] scaled_p1;

    function automatic logic [OUT_W-1:0] sat(input logic [PROD_W-1:0] v);
        if (v > PROD_W'(MAX_VAL))
            return OUT_W'(MAX_VAL);
        return v[OUT_W-1:0];
    endfunction

    assign prod_p1   = PROD_W'(din) * PROD_W'(COEF);
    assign scaled_p1 = prod_p1 >> SHIFT;

    // S1 -> S2 boundary: scaled value lands in the output register
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (en)
            dout <= sat(scaled_p1);
    end

endmodule

// File: rtl/event_normalizer.sv
// Slices raw DVS events into time windows and scales x/y/t into the graph cube, two pipeline stages.
module event_normalizer #(
    parameter int SENSOR_W    = graph_pkg::SENSOR_W,
    parameter int SENSOR_H    = graph_pkg::SENSOR_H,
    parameter int TS_WIDTH    = graph_pkg::TS_WIDTH,
    parameter int GRAPH_SIZE  = graph_pkg::GRAPH_SIZE,
    parameter int TIME_WINDOW = graph_pkg::TIME_WINDOW
) (
    input logic               clk,
    input logic               rst,
    event_normalizer_if.slave bus
);
    import graph_pkg::*;

    localparam int              DT_W = $clog2(TIME_WINDOW);
    localparam int              GW   = GRAPH_BIT_WIDTH;
    localparam longint unsigned XMUL = (longint'(GRAPH_SIZE) << 16) / longint'(SENSOR_W);
    localparam longint unsigned YMUL = (longint'(GRAPH_SIZE) << 16) / longint'(SENSOR_H);
    localparam longint unsigned TMUL = (longint'(GRAPH_SIZE) << 24) / longint'(TIME_WINDOW);

    logic                adv_p1, adv_p2;
    logic                accept, in_range, new_win;
    logic [TS_WIDTH-1:0] ts_diff;

    win_state_t          win_state;
    logic                flush_pending;
    logic [TS_WIDTH-1:0] win_start;
    logic [15:0]         drop_cnt;

    logic                vld_p1, nw_p1, p_p1;
    logic [15:0]         x_p1, y_p1;
    logic [DT_W-1:0]     dt_p1;

    logic                vld_p2, nw_p2, p_p2;
    logic [GW-1:0]       x_p2, y_p2, t_p2;

    assign adv_p2       = !vld_p2 || bus.ev_out_ready;
    assign adv_p1       = !vld_p1 || adv_p2;
    assign bus.in_ready = !rst && adv_p1;
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_range     = (bus.in_x < 16'(SENSOR_W)) && (bus.in_y < 16'(SENSOR_H));
    assign ts_diff      = bus.in_ts - win_start;
    // A timestamp behind win_start means the counter wrapped, so it also opens a window
    assign new_win      = (win_state == IDLE) || flush_pending || bus.flush ||
                          (bus.in_ts < win_start) || (ts_diff >= TS_WIDTH'(TIME_WINDOW));

    // Input -> S1 boundary: window FSM, drop counter, S1 valid
    always_ff @(posedge clk) begin
        if (rst) begin
            win_state     <= IDLE;
            flush_pending <= 1'b0;
            vld_p1        <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (accept && in_range) begin
                if (new_win) begin
                    win_state     <= ACTIVE;
                    flush_pending <= 1'b0;
                end
            end else if (bus.flush) begin
                flush_pending <= 1'b1;
            end
            if (adv_p1)
                vld_p1 <= accept && in_range;
            if (accept && !in_range && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && in_range && new_win)
            win_start <= bus.in_ts;
        if (adv_p1) begin
            x_p1  <= bus.in_x;
            y_p1  <= bus.in_y;
            p_p1  <= bus.in_p;
            nw_p1 <= new_win;
            dt_p1 <= new_win ? '0 : ts_diff[DT_W-1:0];
        end
    end

    // S1 -> S2 boundary: output register, with the three scalers below
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            nw_p2  <= 1'b0;
            p_p2   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            nw_p2  <= nw_p1;
            p_p2   <= p_p1;
        end
    end

    norm_scale #(.DATA_W(16), .COEF(XMUL), .SHIFT(16), .OUT_W(GW), .MAX_VAL(GRAPH_SIZE-1)) u_scale_x (
        .clk(clk), .rst(rst), .en(adv_p2), .din(x_p1), .dout(x_p2)
    );

    norm_scale #(.DATA_W(16), .COEF(YMUL), .SHIFT(16), .OUT_W(GW), .MAX_VAL(GRAPH_SIZE-1)) u_scale_y (
        .clk(clk), .rst(rst), .en(adv_p2), .din(y_p1), .dout(y_p2)
    );

    norm_scale #(.DATA_W(DT_W), .COEF(TMUL), .SHIFT(24), .OUT_W(GW), .MAX_VAL(GRAPH_SIZE-1)) u_scale_t (
        .clk(clk), .rst(rst), .en(adv_p2), .din(dt_p1), .dout(t_p2)
    );

    assign bus.ev_out     = '{valid: vld_p2, x: x_p2, y: y_p2, t: t_p2, p: p_p2};
    assign bus.new_window = vld_p2 && nw_p2;
    assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_event_normalizer.sv
// Randomized and directed bench for event_normalizer against a window/scaling reference model with a scoreboard.
module tb_event_normalizer;

    localparam longint XMUL = (longint'(128) << 16) / 34;
    localparam longint YMUL = (longint'(128) << 16) / 34;
    localparam longint TMUL = (longint'(128) << 24) / 200000;
    localparam longint TW   = 200000;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [6:0] t;
        logic       p;
        logic       nw;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    event_normalizer_if #(.TS_WIDTH(32)) bus ();

    event_normalizer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_emitted = 0;
    exp_t        exp_q[$];
    bit          m_active, m_pend;
    logic [31:0] m_start;
    int          m_drop;
    logic        s_vld, s_in_ready, prev_stall;
    exp_t        s_out, prev_out, last_out;
    logic [31:0] cur_ts;

    task automatic chk(input string tag, input longint obs, input longint req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: observed %0d, required %0d", tag, obs, req);
        end
    endtask

    function automatic logic [6:0] scale(input longint v, input longint mul, input int sh);
        longint r;
        r = (v * mul) >> sh;
        if (r > 127) r = 127;
        return 7'(r);
    endfunction

    function automatic exp_t mk(input int x, input int y, input int t, input bit p, input bit nw);
        exp_t e;
        e.x = 7'(x); e.y = 7'(y); e.t = 7'(t); e.p = p; e.nw = nw;
        return e;
    endfunction

    task automatic model_accept(input logic [15:0] x, input logic [15:0] y, input logic [31:0] ts,
                                input logic p, input logic fl);
        exp_t        e;
        bit          nw;
        logic [31:0] dt;
        if (x >= 34 || y >= 34) begin
            if (m_drop < 65535) m_drop++;
            if (fl) m_pend = 1;
            return;
        end
        nw = !m_active || m_pend || fl || (ts < m_start) || (longint'(ts - m_start) >= TW);
        if (nw) begin
            m_start  = ts;
            m_active = 1;
            m_pend   = 0;
            dt       = 0;
        end else begin
            dt = ts - m_start;
        end
        e.x  = scale(longint'(x), XMUL, 16);
        e.y  = scale(longint'(y), YMUL, 16);
        e.t  = scale(longint'(dt), TMUL, 24);
        e.p  = p;
        e.nw = nw;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] ts, input logic p, input logic fl, input logic rdy);
        exp_t e;
        @(negedge clk);
        bus.in_valid     = v;
        bus.in_x         = x;
        bus.in_y         = y;
        bus.in_ts        = ts;
        bus.in_p         = p;
        bus.flush        = fl;
        bus.ev_out_ready = rdy;
        #1;
        s_in_ready = bus.in_ready;
        s_vld      = bus.ev_out.valid;
        s_out      = '{x: bus.ev_out.x, y: bus.ev_out.y, t: bus.ev_out.t, p: bus.ev_out.p, nw: bus.new_window};
        chk("drop_cnt", longint'(bus.drop_cnt), longint'(m_drop));
        if (prev_stall)
            chk("stall_hold", longint'({s_vld, s_out}), longint'({1'b1, prev_out}));
        prev_stall = s_vld && !rdy;
        prev_out   = s_out;
        @(posedge clk);
        if (v && s_in_ready) model_accept(x, y, ts, p, fl);
        else if (fl) m_pend = 1;
        if (s_vld && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", longint'(s_out), -1);
            end else begin
                e = exp_q.pop_front();
                chk("ev_out", longint'(s_out), longint'(e));
                last_out = s_out;
                n_emitted++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input int x, input int y, input int ts, input bit p, input bit fl);
        cycle(1'b1, 16'(x), 16'(y), 32'(ts), p, fl, 1'b1);
        idle(2);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.flush        = 1'b0;
        bus.ev_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", longint'(bus.ev_out.valid), 0);
        chk("rst_ev_out", longint'(bus.ev_out), 0);
        chk("rst_new_window", longint'(bus.new_window), 0);
        chk("rst_drop_cnt", longint'(bus.drop_cnt), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        repeat (n) @(posedge clk);
        exp_q.delete();
        m_active   = 0;
        m_pend     = 0;
        m_drop     = 0;
        prev_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input bit rand_rdy);
        int b = 0;
        while (exp_q.size() > 0 && b < 400) begin
            cycle(1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            b++;
        end
        idle(3);
        chk("drain_empty", longint'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, tries, r;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_ts = '0;
        bus.in_p = 1'b0; bus.flush = 1'b0; bus.ev_out_ready = 1'b0;
        prev_stall = 0;
        do_reset(2);

        // first event opens a window and appears two cycles after the accept
        cycle(1'b1, 16'd0, 16'd0, 32'd1000, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("lat_1cyc_valid", longint'(s_vld), 0);
        idle(1);
        chk("lat_2cyc_valid", longint'(s_vld), 1);
        chk("t1_first", longint'(last_out), longint'(mk(0, 0, 0, 1, 1)));

        // 17*YMUL truncates to 63, one below the ideal midpoint
        send(33, 17, 2563, 0, 0);
        chk("t2_same_window", longint'(last_out), longint'(mk(124, 63, 1, 0, 0)));
        send(5, 5, 200999, 1, 0);
        chk("t2_window_edge", longint'(last_out), longint'(mk(18, 18, 127, 1, 0)));

        send(0, 33, 201000, 0, 0);
        chk("t3_rollover", longint'(last_out), longint'(mk(0, 124, 0, 0, 1)));
        send(1, 1, 500, 1, 0);
        chk("t3_ts_wrap", longint'(last_out), longint'(mk(3, 3, 0, 1, 1)));

        cycle(1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(3);
        send(2, 2, 5000, 0, 0);
        chk("t4_flush_idle", longint'(last_out), longint'(mk(7, 7, 0, 0, 1)));
        send(2, 2, 6000, 0, 1);
        chk("t4_flush_coincident", longint'(last_out), longint'(mk(7, 7, 0, 0, 1)));
        cycle(1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        send(2, 2, 7000, 0, 0);
        chk("t4_multi_flush", longint'(last_out), longint'(mk(7, 7, 0, 0, 1)));
        send(2, 2, 8000, 0, 0);
        chk("t4_flush_collapsed", longint'(last_out), longint'(mk(7, 7, 0, 0, 0)));

        base = n_emitted;
        send(34, 0, 9000, 0, 0);
        chk("t5_drop_x", longint'(bus.drop_cnt), 1);
        send(0, 34, 9500, 1, 0);
        chk("t5_drop_y", longint'(bus.drop_cnt), 2);
        chk("t5_no_output", longint'(n_emitted - base), 0);
        send(0, 0, 100000, 0, 0);
        chk("t5_window_kept", longint'(last_out), longint'(mk(0, 0, 59, 0, 0)));

        repeat (65536) cycle(1'b1, 16'd40, 16'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t5_saturated", longint'(bus.drop_cnt), 65535);
        send(50, 50, 0, 0, 0);
        chk("t5_saturated_hold", longint'(bus.drop_cnt), 65535);

        do_reset(2);
        base = n_emitted;
        for (int i = 0; i < 8; i++) begin
            tries = 0;
            do begin
                cycle(1'b1, 16'($urandom_range(0, 33)), 16'($urandom_range(0, 33)),
                      32'(10000 + i * 1000), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                tries++;
            end while (!s_in_ready && tries < 50);
        end
        drain(1'b1);
        chk("t6_count_8", longint'(n_emitted - base), 8);

        cur_ts = 32'd20000;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)      cur_ts = 32'($urandom_range(0, 2000));
            else if (r < 5) cur_ts = cur_ts + 32'(150000 + $urandom_range(0, 100000));
            else            cur_ts = cur_ts + 32'($urandom_range(0, 3000));
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 37)), 16'($urandom_range(0, 37)),
                  cur_ts, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 2) != 0));
        end
        drain(1'b0);

        cycle(1'b1, 16'd40, 16'd0, cur_ts, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'd1, 16'd1, cur_ts + 32'(i), 1'b0, 1'b0, 1'b0);
        do_reset(0);
        base = n_emitted;
        idle(4);
        chk("t6_reset_flushed", longint'(n_emitted - base), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
